// File: rtl/float_pkg.sv
// Shared half-precision constants and stream-FSM state names used by the
// fixed-to-half converter and the half-precision divider stages.
package float_pkg;

   localparam int HALF_EXP_W   = 5;
   localparam int HALF_MAN_W   = 10;
   localparam int HALF_BIAS    = 15;
   localparam int HALF_EXP_MAX = 15;
   localparam int HALF_EXP_MIN = -14;

   localparam logic [15:0] HALF_POS_INF = 16'h7C00;
   localparam logic [15:0] HALF_QNAN    = 16'hFE00;

   typedef enum logic [2:0] {
      get_a,
      convert,
      normalise,
      round,
      pack,
      put_z
   } state_t;

endpackage

// File: rtl/half_round_pack.sv
// Round-to-nearest-even and pack of a normalised half-precision value into a
// registered 16-bit word, saturating to signed infinity on exponent overflow.
module half_round_pack
   import float_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              sign,
   input  logic signed [6:0] exp_in,
   input  logic [10:0]       man,
   input  logic              guard,
   input  logic              round_bit,
   input  logic              sticky,
   output logic [15:0]       z
);

   localparam logic signed [6:0] EXP_MAX_S  = 7'(HALF_EXP_MAX);
   localparam logic signed [6:0] EXP_BIAS_S = 7'(HALF_BIAS);

   logic                inc;
   logic [HALF_MAN_W-1:0] frac;
   logic signed [6:0]   exp_rnd;
   logic [HALF_EXP_W-1:0] exp_bias;
   logic [15:0]         z_next;

   // A carry out of an all-ones mantissa renormalises to 1.0 at the next exponent.
   always_comb begin
      inc      = guard & (round_bit | sticky | man[0]);
      frac     = man[HALF_MAN_W-1:0];
      exp_rnd  = exp_in;
      if (inc) begin
         if (man == 11'h7FF) begin
            frac    = '0;
            exp_rnd = exp_in + 7'sd1;
         end else begin
            frac = 10'(man + 11'd1);
         end
      end
      exp_bias = 5'(exp_rnd + EXP_BIAS_S);
      if (exp_rnd > EXP_MAX_S) begin
         z_next = {sign, HALF_POS_INF[14:0]};
      end else begin
         z_next = {sign, exp_bias, frac};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         z <= '0;
      end else if (load) begin
         z <= z_next;
      end
   end

endmodule

// File: rtl/fixed_to_half.sv
// Signed fixed-point to IEEE-754 half converter with a strobe/ack stream on
// both sides, normalising one bit per cycle ahead of a shared round/pack stage.
module fixed_to_half
   import float_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int FRAC  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] input_a,
   input  logic             input_a_stb,
   output logic             input_a_ack,
   output logic [15:0]      output_z,
   output logic             output_z_stb,
   input  logic             output_z_ack
);

   localparam int                EXT_W  = WIDTH + 13;
   localparam logic signed [6:0] E_INIT = 7'(WIDTH - 1 - FRAC);

   state_t            state;
   state_t            state_next;
   logic [WIDTH-1:0]  a;
   logic [WIDTH-1:0]  mag;
   logic signed [6:0] z_e;
   logic              z_s;
   logic              is_zero;
   logic [10:0]       z_m;
   logic              guard;
   logic              round_bit;
   logic              sticky;
   logic [EXT_W-1:0]  ext;
   logic [15:0]       packed_z;

   // Zero padding lets narrow inputs share the same mantissa/guard/round/sticky taps.
   assign ext = {mag, 13'b0};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= get_a;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         get_a:     if (input_a_ack && input_a_stb) state_next = convert;
         convert:   state_next = (a == '0) ? put_z : normalise;
         normalise: if (mag[WIDTH-1]) state_next = round;
         round:     state_next = pack;
         pack:      state_next = put_z;
         put_z:     if (output_z_stb && output_z_ack) state_next = get_a;
         default:   state_next = get_a;
      endcase
   end

   // Unary minus on the most negative input yields 2^(WIDTH-1) as unsigned, as wanted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         input_a_ack  <= 1'b0;
         output_z_stb <= 1'b0;
         output_z     <= '0;
         a            <= '0;
         mag          <= '0;
         z_e          <= '0;
         z_s          <= 1'b0;
         is_zero      <= 1'b0;
         z_m          <= '0;
         guard        <= 1'b0;
         round_bit    <= 1'b0;
         sticky       <= 1'b0;
      end else begin
         case (state)
            get_a: begin
               input_a_ack <= 1'b1;
               if (input_a_ack && input_a_stb) begin
                  a           <= input_a;
                  input_a_ack <= 1'b0;
               end
            end
            convert: begin
               is_zero <= (a == '0);
               z_s     <= a[WIDTH-1];
               mag     <= a[WIDTH-1] ? -a : a;
               z_e     <= E_INIT;
            end
            normalise: begin
               if (!mag[WIDTH-1]) begin
                  mag <= mag << 1;
                  z_e <= z_e - 7'sd1;
               end
            end
            round: begin
               z_m       <= ext[EXT_W-1 -: 11];
               guard     <= ext[WIDTH+1];
               round_bit <= ext[WIDTH];
               sticky    <= |ext[WIDTH-1:0];
            end
            put_z: begin
               if (!output_z_stb) begin
                  output_z_stb <= 1'b1;
                  output_z     <= is_zero ? 16'h0000 : packed_z;
               end else if (output_z_ack) begin
                  output_z_stb <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   half_round_pack u_round_pack (
      .clk       (clk),
      .rst       (rst),
      .load      (state == pack),
      .sign      (z_s),
      .exp_in    (z_e),
      .man       (z_m),
      .guard     (guard),
      .round_bit (round_bit),
      .sticky    (sticky),
      .z         (packed_z)
   );

endmodule

// File: tb/tb_fixed_to_half.sv
// Directed bench for fixed_to_half: Q8.8, integer rounding, 32-bit overflow,
// back-pressure, mid-conversion reset and a two-operand divider hand-off.
module tb_fixed_to_half;

   logic        clk;
   logic        rst;
   logic [15:0] din_m, din_b, din_r;
   logic [31:0] din_o;
   logic        stb_m, stb_b, stb_r, stb_o;
   logic        zack_m, zack_b, zack_r, zack_o;
   logic        ack_m, ack_b, ack_r, ack_o;
   logic [15:0] z_m, z_b, z_r, z_o;
   logic        zs_m, zs_b, zs_r, zs_o;

   int checks;
   int passed;
   int failed;

   fixed_to_half #(.WIDTH(16), .FRAC(8)) dut (
      .clk(clk), .rst(rst), .input_a(din_m), .input_a_stb(stb_m), .input_a_ack(ack_m),
      .output_z(z_m), .output_z_stb(zs_m), .output_z_ack(zack_m));

   fixed_to_half #(.WIDTH(16), .FRAC(8)) dut_b (
      .clk(clk), .rst(rst), .input_a(din_b), .input_a_stb(stb_b), .input_a_ack(ack_b),
      .output_z(z_b), .output_z_stb(zs_b), .output_z_ack(zack_b));

   fixed_to_half #(.WIDTH(16), .FRAC(0)) dut_r (
      .clk(clk), .rst(rst), .input_a(din_r), .input_a_stb(stb_r), .input_a_ack(ack_r),
      .output_z(z_r), .output_z_stb(zs_r), .output_z_ack(zack_r));

   fixed_to_half #(.WIDTH(32), .FRAC(0)) dut_o (
      .clk(clk), .rst(rst), .input_a(din_o), .input_a_stb(stb_o), .input_a_ack(ack_o),
      .output_z(z_o), .output_z_stb(zs_o), .output_z_ack(zack_o));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic f_ack(input int s);
      case (s)
         0: return ack_m;
         1: return ack_b;
         2: return ack_r;
         default: return ack_o;
      endcase
   endfunction

   function automatic logic f_zstb(input int s);
      case (s)
         0: return zs_m;
         1: return zs_b;
         2: return zs_r;
         default: return zs_o;
      endcase
   endfunction

   function automatic logic [15:0] f_z(input int s);
      case (s)
         0: return z_m;
         1: return z_b;
         2: return z_r;
         default: return z_o;
      endcase
   endfunction

   task automatic drive(input int s, input logic [31:0] v, input logic st);
      case (s)
         0: begin din_m = v[15:0]; stb_m = st; end
         1: begin din_b = v[15:0]; stb_b = st; end
         2: begin din_r = v[15:0]; stb_r = st; end
         default: begin din_o = v; stb_o = st; end
      endcase
   endtask

   task automatic set_zack(input int s, input logic v);
      case (s)
         0: zack_m = v;
         1: zack_b = v;
         2: zack_r = v;
         default: zack_o = v;
      endcase
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) passed++;
      else begin
         failed++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   // Truncating half divider for normal operands; enough for exact quotients.
   function automatic logic [15:0] half_div(input logic [15:0] x, input logic [15:0] y);
      logic [21:0] q;
      logic [10:0] mx, my;
      int          e;
      mx = {1'b1, x[9:0]};
      my = {1'b1, y[9:0]};
      q  = {mx, 11'b0} / {11'b0, my};
      e  = int'(x[14:10]) - int'(y[14:10]) + 15;
      if (q[11]) return {x[15] ^ y[15], 5'(e), q[10:1]};
      else       return {x[15] ^ y[15], 5'(e - 1), q[9:0]};
   endfunction

   // Handshake one operand in and wait for the result; lat counts edges after capture.
   task automatic convert_op(input int s, input logic [31:0] v,
                             output int lat, output logic [15:0] res, output logic ok);
      int n;
      drive(s, v, 1'b1);
      n = 0;
      while (!f_ack(s) && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      drive(s, v, 1'b0);
      lat = 0;
      ok  = 1'b0;
      while (!ok && lat < 64) begin
         @(posedge clk); #1;
         lat++;
         ok = f_zstb(s);
      end
      res = f_z(s);
   endtask

   task automatic accept(input int s);
      set_zack(s, 1'b1);
      @(posedge clk); #1;
      set_zack(s, 1'b0);
   endtask

   task automatic apply_stimulus(input int s, input logic [31:0] v, input logic [15:0] expz,
                                 input int explat, input string tag);
      int          lat;
      logic [15:0] res;
      logic        ok;
      convert_op(s, v, lat, res, ok);
      check_output({tag, "_valid"}, 32'(ok), 32'd1);
      check_output({tag, "_z"}, 32'(res), 32'(expz));
      if (explat > 0) check_output({tag, "_lat"}, 32'(lat), 32'(explat));
      accept(s);
   endtask

   initial begin
      int          lat;
      logic [15:0] res, held, za, zb;
      logic        ok, stable, stale;

      checks = 0; passed = 0; failed = 0;
      rst = 1'b0;
      din_m = '0; din_b = '0; din_r = '0; din_o = '0;
      stb_m = 1'b0; stb_b = 1'b0; stb_r = 1'b0; stb_o = 1'b0;
      zack_m = 1'b0; zack_b = 1'b0; zack_r = 1'b0; zack_o = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check_output("reset_ack", 32'(ack_m), 32'd0);
      check_output("reset_stb", 32'(zs_m), 32'd0);
      check_output("reset_z", 32'(z_m), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;

      $display("[TB] Q8.8 conversions");
      apply_stimulus(0, 32'h0100, 16'h3C00, 12, "q88_one");
      apply_stimulus(0, 32'hFF00, 16'hBC00, 12, "q88_neg_one");
      apply_stimulus(0, 32'h0000, 16'h0000, 2,  "q88_zero");
      apply_stimulus(0, 32'h8000, 16'hD800, 5,  "q88_most_neg");
      apply_stimulus(0, 32'h0001, 16'h1C00, 20, "q88_lsb");

      $display("[TB] integer rounding");
      apply_stimulus(2, 32'h0801, 16'h6800, 0, "rne_tie_even");
      apply_stimulus(2, 32'h0803, 16'h6802, 0, "rne_tie_odd");
      apply_stimulus(2, 32'h0FFF, 16'h6C00, 0, "rne_carry");

      $display("[TB] 32-bit overflow");
      apply_stimulus(3, 32'h7FFFFFFF, 16'h7C00, 0, "ovf_pos_max");
      apply_stimulus(3, 32'h80000000, 16'hFC00, 0, "ovf_neg_max");
      apply_stimulus(3, 32'h0000FFF0, 16'h7C00, 0, "ovf_round_up");

      $display("[TB] back-pressure");
      convert_op(0, 32'h0180, lat, res, ok);
      check_output("bp_z", 32'(res), 32'h3E00);
      check_output("bp_lat", 32'(lat), 32'd12);
      held   = res;
      stable = ok;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (z_m !== held || zs_m !== 1'b1 || ack_m !== 1'b0) stable = 1'b0;
      end
      check_output("bp_stable", 32'(stable), 32'd1);
      accept(0);
      check_output("bp_stb_fall", 32'(zs_m), 32'd0);
      check_output("bp_ack_low", 32'(ack_m), 32'd0);
      @(posedge clk); #1;
      check_output("bp_ack_rise", 32'(ack_m), 32'd1);

      $display("[TB] reset during normalise");
      drive(0, 32'h0001, 1'b1);
      @(posedge clk); #1;
      drive(0, 32'h0001, 1'b0);
      repeat (6) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check_output("rst_mid_ack", 32'(ack_m), 32'd0);
      check_output("rst_mid_stb", 32'(zs_m), 32'd0);
      check_output("rst_mid_z", 32'(z_m), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      stale = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (zs_m) stale = 1'b1;
      end
      check_output("rst_no_stale", 32'(stale), 32'd0);
      apply_stimulus(0, 32'h0100, 16'h3C00, 12, "rst_recover");

      $display("[TB] divider operand pair");
      convert_op(0, 32'h0180, lat, za, ok);
      check_output("div_a", 32'(za), 32'h3E00);
      accept(0);
      convert_op(1, 32'h0080, lat, zb, ok);
      check_output("div_b", 32'(zb), 32'h3800);
      accept(1);
      check_output("div_q", 32'(half_div(za, zb)), 32'h4200);

      $display("[TB] %0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/fixed_to_half.md
Name: fixed_to_half

Overview:
- Converts a signed two's-complement fixed-point word into an IEEE-754 half-precision float.
- Sits directly upstream of the half-precision divider and drives its input_a/input_b ports; one instance per divider operand.
- Multi-cycle FSM with the same strobe/ack handshake on both sides as the divider, so the two connect port-to-port.

Parameters:
- WIDTH, 16, total fixed-point input width in bits; legal range 2..32.
- FRAC, 8, number of fractional bits; legal range 0..min(WIDTH-1, 14). This range guarantees no subnormal results.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset; one clock; reset is asynchronous and active-low
- input_a  input  WIDTH  fixed-point operand; value = signed(input_a) / 2^FRAC
- input_a_stb  input  1  upstream data valid
- input_a_ack  output  1  block ready; transfer occurs when input_a_ack && input_a_stb
- output_z  output  16  half-float result {sign, exp[4:0], man[9:0]}
- output_z_stb  output  1  result valid
- output_z_ack  input  1  downstream accept; transfer occurs when output_z_stb && output_z_ack

Behaviour:
- Reset (asynchronous, rst low):
  - state=get_a; input_a_ack=0; output_z_stb=0; output_z=0.
  - Any in-flight conversion is discarded. Reset asserted mid-operation returns to get_a with no output strobe.
- get_a:
  - Drive ack=1.
  - On ack&&stb: capture input_a, ack<=0, go to convert.
  - ack rises one cycle after entering get_a.
- convert:
  - If a==0: z=16'h0000, go to put_z. Negative zero is never produced.
  - Else: z_s=a[WIDTH-1]; mag=|a| as WIDTH-bit unsigned. The most negative input is handled correctly as unsigned 2^(WIDTH-1).
  - z_e = WIDTH-1-FRAC as a signed 7-bit value; go to normalise.
- normalise:
  - While mag[WIDTH-1]==0: mag<<=1, z_e-=1; one bit per cycle.
  - When the MSB is set, go to round. Cost is (leading zeros + 1) cycles.
- round:
  - z_m = top 11 bits of mag, zero-padded on the right if WIDTH<11.
  - guard = next bit; round_bit = bit after that; sticky = OR of all remaining bits.
  - Round to nearest, ties to even: increment when guard && (round_bit | sticky | z_m[0]).
  - If z_m==11'h7FF before the increment: z_m<=11'h400 and z_e+=1.
  - Go to pack.
- pack:
  - z = {z_s, z_e+15, z_m[9:0]}.
  - If z_e>15: z = {z_s, 5'h1F, 10'h0} (signed infinity saturation).
  - NaN is never produced. Go to put_z.
- put_z:
  - output_z_stb<=1, output_z<=z.
  - On stb&&ack: stb<=0, go to get_a.
  - output_z is held stable while stb=1 and ack=0 (back-pressure is unbounded).
  - ack already high while stb is being set counts as immediate accept one cycle after stb rises.
- Latency, capture edge to output_z_stb high:
  - 4 + (leading zeros of |a| + 1) cycles.
  - 2 cycles for zero input (convert then put_z, stb one edge later).
- Throughput: one conversion in flight; input_a_ack stays low from capture until the output transfer completes.
- Simultaneous input_a_stb and output activity cannot occur, because the states are exclusive.

Decomposition:
- Shared package float_pkg:
  - HALF_EXP_W=5, HALF_MAN_W=10, HALF_BIAS=15, HALF_EXP_MAX=15, HALF_EXP_MIN=-14
  - HALF_POS_INF=16'h7C00, HALF_QNAN=16'hFE00
  - state encodings for shared stream-FSM names: get_a, put_z
- One natural sub-module: half_round_pack.
  - Inputs: sign, signed exponent, 11-bit mantissa, guard/round/sticky.
  - Output: registered 16-bit packed word, with RNE rounding and overflow-to-infinity.
  - Reusable by the divider and other half-precision stages.
- Normalisation and handshake stay in the top module.

Test Plan:
- Default Q8.8:
  - 0x0100 → 0x3C00
  - 0xFF00 → 0xBC00
  - 0x0000 → 0x0000 (2 cycles after capture)
  - 0x8000 → 0xD800
  - 0x0001 → 0x1C00 (16 normalise cycles, latency 20)
- Rounding with WIDTH=16, FRAC=0:
  - 0x0801 (2049, tie, even LSB) → 0x6800
  - 0x0803 (2051, tie, odd LSB) → 0x6802
  - 0x0FFF (4095, mantissa carry) → 0x6C00
- Overflow with WIDTH=32, FRAC=0:
  - 0x7FFFFFFF → 0x7C00
  - 0x80000000 → 0xFC00
  - 0x0000FFF0 (65520, rounds up) → 0x7C00
- Back-pressure: hold output_z_ack=0 for 10 cycles after stb.
  - output_z and stb stay stable; input_a_ack stays 0.
  - After ack, stb falls next edge and input_a_ack rises one cycle later.
- Reset mid-normalise: apply 0x0001, pull rst low during normalise.
  - Immediately: input_a_ack=0, output_z_stb=0, output_z=0.
  - After release, no stale result appears.
  - Next conversion 0x0100 yields 0x3C00.
- Back-to-back streaming into the divider model: pairs (1.5, 0.5) in Q8.8 (0x0180, 0x0080).
  - Converter outputs 0x3E00 and 0x3800.
  - Divider output 0x4200.
